// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the button controller: debounce defaults and the short
// debounce length used in simulation.
package btn_ctrl_pkg;

  localparam int unsigned DEB_CYCLES_DEFAULT = 500000;  // 5 ms at 100 MHz
  localparam int unsigned CNT_W_DEFAULT      = 20;
  localparam int unsigned DEB_CYCLES_SIM     = 4;

endpackage

// File: rtl/btn_ctrl_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// and a strobe that is high in the cycle whose edge makes the level rise.
module btn_ctrl_debounce
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic [1:0]       r_sync;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_sync[1] ^ r_db;
  // The counter can hold DEB_CYCLES, which places the level change DEB_CYCLES+2
  // edges after the raw level is first sampled.
  assign w_flip = w_diff && (r_cnt == CNT_W'(DEB_CYCLES));
  assign o_rise = w_flip && r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_flip) begin
        r_db <= r_sync[1];
      end
    end
  end

endmodule

// File: rtl/btn_ctrl.sv
// Pause/reset button controller: debounces both buttons, toggles the pause level
// on each pause press and emits one-cycle reset and pause-event pulses.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_rst,
  output logic pause,
  output logic rst,
  output logic pause_ev
);

  logic w_pause_rise;
  logic w_rst_rise;
  logic r_pause;
  logic r_rst;
  logic r_pause_ev;

  btn_ctrl_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_pause (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (btn_pause),
    .o_rise (w_pause_rise)
  );

  btn_ctrl_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_rst (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (btn_rst),
    .o_rise (w_rst_rise)
  );

  // Outputs update on the same edge the debounced level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause    <= 1'b0;
      r_rst      <= 1'b0;
      r_pause_ev <= 1'b0;
    end else begin
      r_pause    <= r_pause ^ w_pause_rise;
      r_pause_ev <= w_pause_rise;
      r_rst      <= w_rst_rise;
    end
  end

  assign pause    = r_pause;
  assign rst      = r_rst;
  assign pause_ev = r_pause_ev;

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl with the short simulation debounce: directed press, bounce,
// reset-button, simultaneous and async-reset cases, then random bouncing input.
module tb_btn_ctrl;
  import btn_ctrl_pkg::*;

  localparam int unsigned Deb = DEB_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_pause;
  logic btn_rst;
  logic pause;
  logic rst;
  logic pause_ev;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: a level is accepted once Deb+1 consecutive raw samples,
  // ending two edges ago, all agree and differ from the current level.
  logic q_p[$];
  logic q_r[$];
  logic db_p, db_r;
  logic m_pause, m_pev, m_rst;
  logic [4:0] bpat;

  btn_ctrl #(
    .DEB_CYCLES(Deb),
    .CNT_W     (3)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_pause(btn_pause),
    .btn_rst  (btn_rst),
    .pause    (pause),
    .rst      (rst),
    .pause_ev (pause_ev)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q_p.delete();
    q_r.delete();
    for (int i = 0; i < int'(Deb) + 2; i++) begin
      q_p.push_back(1'b0);
      q_r.push_back(1'b0);
    end
    db_p = 1'b0; db_r = 1'b0;
    m_pause = 1'b0; m_pev = 1'b0; m_rst = 1'b0;
  endtask

  function automatic logic win_flip(input logic q[$], input logic db, output logic v);
    logic ok;
    v  = q[0];
    ok = (v != db);
    for (int i = 1; i <= int'(Deb); i++) if (q[i] != v) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_edge(input logic p, input logic r);
    logic vp, vr;
    q_p.push_back(p);
    q_r.push_back(r);
    if (q_p.size() > Deb + 3) void'(q_p.pop_front());
    if (q_r.size() > Deb + 3) void'(q_r.pop_front());
    m_pev = 1'b0;
    m_rst = 1'b0;
    if (win_flip(q_p, db_p, vp)) begin
      db_p = vp;
      if (vp) begin
        m_pause = ~m_pause;
        m_pev   = 1'b1;
      end
    end
    if (win_flip(q_r, db_r, vr)) begin
      db_r = vr;
      if (vr) m_rst = 1'b1;
    end
  endtask

  // Called in the low clock phase; drives inputs, clocks once, checks at negedge.
  task automatic step(input logic p, input logic r);
    btn_pause = p;
    btn_rst   = r;
    @(posedge clk);
    if (rst_n) model_edge(p, r);
    @(negedge clk);
    check("pause", pause, m_pause);
    check("pause_ev", pause_ev, m_pev);
    check("rst", rst, m_rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    logic lp, lr;
    int run_p, run_r;
    rst_n = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0;
    bpat = 5'b01101;  // edges 5..9 of the bounce case: 1,0,1,1,0
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pause", pause, 1'b0);
    check("reset_pause_ev", pause_ev, 1'b0);
    check("reset_rst", rst, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Clean press held 20 cycles, then released.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) check("clean_pause_e5", pause, 1'b0);
      if (i == 6) check("clean_ev_e6", pause_ev, 1'b1);
      if (i == 6) check("clean_pause_e6", pause, 1'b1);
    end
    idle(12);

    // Bounce, then steady high from edge 10.
    for (int i = 0; i < 30; i++) begin
      step((i < 5) ? 1'b0 : (i < 10) ? bpat[i-5] : 1'b1, 1'b0);
      if (i == 15) check("bounce_ev_e15", pause_ev, 1'b0);
      if (i == 16) check("bounce_ev_e16", pause_ev, 1'b1);
    end
    idle(12);

    // Two full press/release cycles.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      idle(10);
    end

    // Reset button with pause set.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1);
      if (i == 6) check("rstbtn_rst_e6", rst, 1'b1);
      if (i == 6) check("rstbtn_pause_e6", pause, 1'b1);
      if (i == 7) check("rstbtn_rst_e7", rst, 1'b0);
    end
    idle(10);

    // Simultaneous presses.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 6) check("sim_rst_e6", rst, 1'b1);
      if (i == 6) check("sim_ev_e6", pause_ev, 1'b1);
      if (i == 6) check("sim_pause_e6", pause, 1'b0);
    end
    idle(10);

    // Async reset in the middle of a count with pause set.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_pause", pause, 1'b0);
    check("areset_ev", pause_ev, 1'b0);
    check("areset_rst", rst, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) check("areset_ev_e5", pause_ev, 1'b0);
      if (i == 6) check("areset_ev_e6", pause_ev, 1'b1);
    end
    idle(10);

    // Random bouncing with run lengths around the debounce window.
    lp = 1'b0; lr = 1'b0;
    run_p = $urandom_range(1, 9);
    run_r = $urandom_range(1, 9);
    for (int i = 0; i < 600; i++) begin
      if (--run_p == 0) begin lp = ~lp; run_p = $urandom_range(1, 9); end
      if (--run_r == 0) begin lr = ~lr; run_r = $urandom_range(1, 9); end
      step(lp, lr);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
